data_mem_sized: RTL and testbench

- Next-generation byte-addressable, big-endian data memory for the MIPS datapath.
- Replaces the single byte/word flag with byte, half and word access sizes, sign/zero-extended loads and range/alignment error reporting.
- Adds a req/ready/done handshake with a parametrised access latency, so the pipeline can model slower memory.
- Sits between the MEM stage and backing storage.

---
 rtl/data_mem_sized_if.sv | 30 +++
 rtl/data_mem_sized.sv | 225 ++++++++++++++++++++++
 tb/tb_data_mem_sized.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_sized_if.sv
// ---------------------------------------------------------------------------
// data_mem_sized_if
// Request/response bundle between the MEM stage and data_mem_sized.
//   master : drives w_req, w_write_op, w_size_2, w_signed, w_addr_32,
//            w_data_in_32; observes w_ready, w_done, w_error, w_data_out_32.
//   slave  : the memory side of the same signals.
// Size encoding on w_size_2: 00 byte, 01 half, 10 word, 11 reserved.
// ---------------------------------------------------------------------------
interface data_mem_sized_if;
  logic        w_req;
  logic        w_write_op;
  logic [1:0]  w_size_2;
  logic        w_signed;
  logic [31:0] w_addr_32;
  logic [31:0] w_data_in_32;
  logic        w_ready;
  logic        w_done;
  logic        w_error;
  logic [31:0] w_data_out_32;

  modport master (
    output w_req, w_write_op, w_size_2, w_signed, w_addr_32, w_data_in_32,
    input  w_ready, w_done, w_error, w_data_out_32
  );

  modport slave (
    input  w_req, w_write_op, w_size_2, w_signed, w_addr_32, w_data_in_32,
    output w_ready, w_done, w_error, w_data_out_32
  );
endinterface

// File: rtl/data_mem_sized.sv
// ---------------------------------------------------------------------------
// data_mem_sized
// Byte-addressable, big-endian data memory with byte/half/word accesses,
// sign/zero-extended loads, range/alignment error reporting and a
// req/ready/done handshake with a configurable access latency.
//
// Ports:
//   clock - rising-edge clock for all state
//   reset - synchronous, active-high reset (memory contents are kept)
//   bus   - data_mem_sized_if.slave: request fields in, ready/done/error/
//           load data out
//
// Parameters:
//   MEM_DEPTH - bytes of storage, valid addresses 0..MEM_DEPTH-1
//   LATENCY   - cycles from accept to the done pulse (1..15)
//   CNT_W     - latency counter width, must hold LATENCY
//
// Build option:
//   DATA_MEM_ALIGN_CHECK_EN - when defined, misaligned half/word accesses are
//   rejected with w_error. When undefined, the address is silently aligned
//   (half clears bit 0, word clears bits 1:0) before range checks and use.
// ---------------------------------------------------------------------------
module data_mem_sized #(
  parameter int MEM_DEPTH = 4096,
  parameter int LATENCY   = 1,
  parameter int CNT_W     = 4
) (
  input  logic              clock,
  input  logic              reset,
  data_mem_sized_if.slave   bus
);

  localparam int AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  logic [7:0]       mem [MEM_DEPTH];

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  assign bus.w_ready = (state_q == IDLE) && !reset;
  assign accept      = bus.w_req && bus.w_ready;
  assign bus.w_done  = (state_q == RESP);

  // ---------------------------------------------------------------------
  // Address qualification
  // ---------------------------------------------------------------------
  logic [31:0] addr_eff;
  logic [1:0]  span;
  logic [32:0] last_byte;
  logic        size_err, range_err, align_err, req_err;

  // NOTE: every signal assigned in an always_comb gets a default first so
  // no path leaves it unassigned, which would infer a latch.
  always_comb begin
    addr_eff = bus.w_addr_32;
`ifndef DATA_MEM_ALIGN_CHECK_EN
    if (bus.w_size_2 == SZ_HALF)      addr_eff[0]   = 1'b0;
    else if (bus.w_size_2 == SZ_WORD) addr_eff[1:0] = 2'b00;
`endif
  end

  always_comb begin
    span = 2'd0;
    case (bus.w_size_2)
      SZ_HALF: span = 2'd1;
      SZ_WORD: span = 2'd3;
      default: span = 2'd0;
    endcase
  end

  // One extra bit keeps addresses near 2^32 from wrapping back into range.
  assign last_byte = {1'b0, addr_eff} + {31'b0, span};
  assign size_err  = (bus.w_size_2 == 2'b11);
  assign range_err = (last_byte >= 33'(MEM_DEPTH));

`ifdef DATA_MEM_ALIGN_CHECK_EN
  assign align_err = ((bus.w_size_2 == SZ_HALF) && bus.w_addr_32[0]) ||
                     ((bus.w_size_2 == SZ_WORD) && (bus.w_addr_32[1:0] != 2'b00));
`else
  assign align_err = 1'b0;
`endif

  assign req_err = size_err || range_err || align_err;

  // ---------------------------------------------------------------------
  // Byte lanes, big-endian: lane 0 is the most significant byte
  // ---------------------------------------------------------------------
  logic [AW-1:0] a0, a1, a2, a3;
  logic [7:0]    b0, b1, b2, b3;

  assign a0 = addr_eff[AW-1:0];
  assign a1 = a0 + AW'(1);
  assign a2 = a0 + AW'(2);
  assign a3 = a0 + AW'(3);

  // Lanes beyond the access size or an out-of-range address are never used.
  assign b0 = mem[a0];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  logic [31:0] ld_data;
  logic        sx;

  always_comb begin
    ld_data = 32'h0;
    sx      = bus.w_signed && b0[7];
    case (bus.w_size_2)
      SZ_BYTE: ld_data = {{24{sx}}, b0};
      SZ_HALF: ld_data = {{16{sx}}, b0, b1};
      SZ_WORD: ld_data = {b0, b1, b2, b3};
      default: ld_data = 32'h0;
    endcase
  end

  logic [31:0] resp_data;
  assign resp_data = (req_err || bus.w_write_op) ? 32'h0 : ld_data;

  // ---------------------------------------------------------------------
  // Storage: stores commit at the accept edge
  // ---------------------------------------------------------------------
  // NOTE: the byte array has no reset branch on purpose; contents survive
  // reset, and a reset loop over every entry would not map to RAM.
  always_ff @(posedge clock) begin
    if (accept && bus.w_write_op && !req_err) begin
      case (bus.w_size_2)
        SZ_BYTE: mem[a0] <= bus.w_data_in_32[7:0];
        SZ_HALF: begin
          mem[a0] <= bus.w_data_in_32[15:8];
          mem[a1] <= bus.w_data_in_32[7:0];
        end
        SZ_WORD: begin
          mem[a0] <= bus.w_data_in_32[31:24];
          mem[a1] <= bus.w_data_in_32[23:16];
          mem[a2] <= bus.w_data_in_32[15:8];
          mem[a3] <= bus.w_data_in_32[7:0];
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_W'(LATENCY - 1);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------
  // Response registers
  // The result is captured at accept and only published on entry to RESP,
  // so w_error/w_data_out_32 hold the previous response during WAIT.
  // ---------------------------------------------------------------------
  logic [31:0] pend_data_q, dout_q;
  logic        pend_err_q,  err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_data_q <= 32'h0;
      pend_err_q  <= 1'b0;
      dout_q      <= 32'h0;
      err_q       <= 1'b0;
    end else begin
      if (accept) begin
        pend_data_q <= resp_data;
        pend_err_q  <= req_err;
      end
      if (state_d == RESP) begin
        if (state_q == IDLE) begin
          dout_q <= resp_data;
          err_q  <= req_err;
        end else begin
          dout_q <= pend_data_q;
          err_q  <= pend_err_q;
        end
      end
    end
  end

  assign bus.w_data_out_32 = dout_q;
  assign bus.w_error       = err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// ---------------------------------------------------------------------------
// tb_data_mem_sized
// Directed bench for data_mem_sized. Two instances: LATENCY=1 for the data
// path and error checks, LATENCY=4 for handshake timing and mid-operation
// reset. Inputs change after rising edges, outputs are sampled on falling
// edges.
// ---------------------------------------------------------------------------
module tb_data_mem_sized;

  localparam int DEPTH = 4096;

  logic clock = 1'b0;
  logic reset1, reset4;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  data_mem_sized_if if1 ();
  data_mem_sized_if if4 ();

  data_mem_sized #(.MEM_DEPTH(DEPTH), .LATENCY(1), .CNT_W(4)) dut1 (
    .clock (clock),
    .reset (reset1),
    .bus   (if1.slave)
  );

  data_mem_sized #(.MEM_DEPTH(DEPTH), .LATENCY(4), .CNT_W(4)) dut4 (
    .clock (clock),
    .reset (reset4),
    .bus   (if4.slave)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One access on the LATENCY=1 instance; returns the RESP-cycle outputs.
  task automatic op1(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic done, output logic err, output logic [31:0] q);
    @(negedge clock);
    if1.w_write_op   = wr;
    if1.w_size_2     = sz;
    if1.w_signed     = sg;
    if1.w_addr_32    = a;
    if1.w_data_in_32 = d;
    if1.w_req        = 1'b1;
    @(posedge clock);
    #1 if1.w_req = 1'b0;
    @(negedge clock);
    done = if1.w_done;
    err  = if1.w_error;
    q    = if1.w_data_out_32;
  endtask

  // One access on the LATENCY=4 instance with a bounded wait for done.
  task automatic op4(input logic wr, input logic [1:0] sz, input logic sg,
                     input logic [31:0] a, input logic [31:0] d,
                     output logic done, output logic err, output logic [31:0] q);
    @(negedge clock);
    if4.w_write_op   = wr;
    if4.w_size_2     = sz;
    if4.w_signed     = sg;
    if4.w_addr_32    = a;
    if4.w_data_in_32 = d;
    if4.w_req        = 1'b1;
    @(posedge clock);
    #1 if4.w_req = 1'b0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      @(negedge clock);
      done = if4.w_done;
    end
    err = if4.w_error;
    q   = if4.w_data_out_32;
  endtask

  logic        dn, er;
  logic [31:0] q;
  int          waited, pulses;

  initial begin
    reset1 = 1'b1;
    reset4 = 1'b1;
    if1.w_req = 1'b0; if1.w_write_op = 1'b0; if1.w_size_2 = 2'b00;
    if1.w_signed = 1'b0; if1.w_addr_32 = 32'h0; if1.w_data_in_32 = 32'h0;
    if4.w_req = 1'b0; if4.w_write_op = 1'b0; if4.w_size_2 = 2'b00;
    if4.w_signed = 1'b0; if4.w_addr_32 = 32'h0; if4.w_data_in_32 = 32'h0;

    // ------------------------------------------------------------ reset
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_ready", 32'(if1.w_ready), 32'h0);
    check("rst_done",  32'(if1.w_done),  32'h0);
    check("rst_error", 32'(if1.w_error), 32'h0);
    check("rst_dout",  if1.w_data_out_32, 32'h0);
    reset1 = 1'b0;
    reset4 = 1'b0;
    @(negedge clock);
    check("ready_after_rst", 32'(if1.w_ready), 32'h1);

    // ------------------------------------------------ word store + byte loads
    op1(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, dn, er, q);
    check("st_w_done", 32'(dn), 32'h1);
    check("st_w_err",  32'(er), 32'h0);
    check("st_w_dout", q, 32'h0);
    @(negedge clock);
    check("done_one_cycle", 32'(if1.w_done), 32'h0);

    op1(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, dn, er, q); check("ldb_10", q, 32'h000000DE);
    op1(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, dn, er, q); check("ldb_11", q, 32'h000000AD);
    op1(1'b0, 2'b00, 1'b0, 32'h12, 32'h0, dn, er, q); check("ldb_12", q, 32'h000000BE);
    op1(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, dn, er, q); check("ldb_13", q, 32'h000000EF);
    check("ldb_13_err", 32'(er), 32'h0);

    // ------------------------------------------------------ sign extension
    op1(1'b0, 2'b00, 1'b1, 32'h10, 32'h0, dn, er, q); check("ldb_s_10", q, 32'hFFFFFFDE);
    op1(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, dn, er, q); check("ldh_s_12", q, 32'hFFFFBEEF);
    op1(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, dn, er, q); check("ldh_u_12", q, 32'h0000BEEF);
    op1(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, dn, er, q); check("ldh_s_10", q, 32'hFFFFDEAD);

    // ------------------------------------------------------------- hold
    @(negedge clock);
    check("hold_dout", if1.w_data_out_32, 32'hFFFFDEAD);
    check("hold_done", 32'(if1.w_done), 32'h0);

    // ------------------------------------------------------ half / byte store
    op1(1'b1, 2'b01, 1'b0, 32'h30, 32'h0000A1B2, dn, er, q);
    op1(1'b1, 2'b00, 1'b0, 32'h32, 32'h000000C3, dn, er, q);
    op1(1'b0, 2'b10, 1'b0, 32'h30, 32'h0, dn, er, q);
    check("ld_mixed_3x", q[31:8], 32'h00A1B2C3);

    // --------------------------------------------------------- range end
    op1(1'b1, 2'b10, 1'b0, DEPTH - 4, 32'hCAFEF00D, dn, er, q);
    check("st_top_err", 32'(er), 32'h0);
    op1(1'b1, 2'b10, 1'b0, DEPTH - 2, 32'h12345678, dn, er, q);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    check("st_over_err", 32'(er), 32'h1);
    check("st_over_done", 32'(dn), 32'h1);
    op1(1'b0, 2'b10, 1'b0, DEPTH - 4, 32'h0, dn, er, q);
    check("top_unchanged", q, 32'hCAFEF00D);
`else
    check("st_over_err", 32'(er), 32'h0);
    check("st_over_done", 32'(dn), 32'h1);
    op1(1'b0, 2'b10, 1'b0, DEPTH - 4, 32'h0, dn, er, q);
    check("top_aligned", q, 32'h12345678);
`endif
    op1(1'b1, 2'b10, 1'b0, DEPTH, 32'h55555555, dn, er, q);
    check("st_depth_err", 32'(er), 32'h1);
    op1(1'b0, 2'b00, 1'b0, DEPTH - 1, 32'h0, dn, er, q);
    check("ldb_last_err", 32'(er), 32'h0);
    op1(1'b0, 2'b00, 1'b0, DEPTH, 32'h0, dn, er, q);
    check("ldb_depth_err", 32'(er), 32'h1);
    check("ldb_depth_dout", q, 32'h0);
    op1(1'b0, 2'b00, 1'b0, 32'hFFFFFFFF, 32'h0, dn, er, q);
    check("ldb_max_err", 32'(er), 32'h1);

    // ------------------------------------------------------- misalignment
    op1(1'b0, 2'b10, 1'b0, 32'h11, 32'h0, dn, er, q);
`ifdef DATA_MEM_ALIGN_CHECK_EN
    check("ldw_11_err",  32'(er), 32'h1);
    check("ldw_11_dout", q, 32'h0);
`else
    check("ldw_11_err",  32'(er), 32'h0);
    check("ldw_11_dout", q, 32'hDEADBEEF);
`endif

    // ------------------------------------------------------ reserved size
    op1(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, dn, er, q);
    check("sz11_err",  32'(er), 32'h1);
    check("sz11_dout", q, 32'h0);
    op1(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, dn, er, q);
    check("after_err_err",  32'(er), 32'h0);
    check("after_err_dout", q, 32'hDEADBEEF);

    // --------------------------------------------- LATENCY=4 handshake timing
    @(negedge clock);
    if4.w_write_op = 1'b1; if4.w_size_2 = 2'b10; if4.w_signed = 1'b0;
    if4.w_addr_32 = 32'h40; if4.w_data_in_32 = 32'hA5A5A5A5;
    if4.w_req = 1'b1;
    @(posedge clock);                       // edge N: store accepted
    #1 if4.w_write_op = 1'b0;               // req stays high: next is a load
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check($sformatf("l4_wait_ready_%0d", i), 32'(if4.w_ready), 32'h0);
      check($sformatf("l4_wait_done_%0d", i),  32'(if4.w_done),  32'h0);
    end
    @(negedge clock);
    check("l4_resp_done",  32'(if4.w_done),  32'h1);
    check("l4_resp_ready", 32'(if4.w_ready), 32'h0);
    check("l4_resp_err",   32'(if4.w_error), 32'h0);
    @(negedge clock);
    check("l4_idle_ready", 32'(if4.w_ready), 32'h1);
    check("l4_idle_done",  32'(if4.w_done),  32'h0);
    @(posedge clock);                       // edge N+5: held req accepted
    #1 if4.w_req = 1'b0;
    @(negedge clock);
    check("l4_reaccept", 32'(if4.w_ready), 32'h0);
    waited = 0;
    dn = 1'b0;
    for (int k = 1; k <= 10 && !dn; k++) begin
      @(negedge clock);
      dn = if4.w_done;
      waited = k;
    end
    check("l4_ld_done",  32'(dn), 32'h1);
    check("l4_ld_delay", 32'(waited), 32'd3);
    check("l4_ld_data",  if4.w_data_out_32, 32'hA5A5A5A5);

    // ---------------------------------------- LATENCY=4 reset during WAIT
    @(negedge clock);
    if4.w_write_op = 1'b1; if4.w_size_2 = 2'b10; if4.w_signed = 1'b0;
    if4.w_addr_32 = 32'h20; if4.w_data_in_32 = 32'h11223344;
    if4.w_req = 1'b1;
    @(posedge clock);
    #1 if4.w_req = 1'b0;
    @(negedge clock);                       // in WAIT
    reset4 = 1'b1;
    // A request presented alongside reset must not be accepted.
    if4.w_data_in_32 = 32'hBAD0BAD0;
    if4.w_req = 1'b1;
    pulses = 0;
    @(negedge clock);
    if (if4.w_done) pulses++;
    check("l4_rst_ready", 32'(if4.w_ready), 32'h0);
    check("l4_rst_err",   32'(if4.w_error), 32'h0);
    check("l4_rst_dout",  if4.w_data_out_32, 32'h0);
    reset4 = 1'b0;
    if4.w_req = 1'b0;
    @(negedge clock);
    check("l4_after_rst_ready", 32'(if4.w_ready), 32'h1);
    for (int k = 0; k < 6; k++) begin
      if (if4.w_done) pulses++;
      @(negedge clock);
    end
    check("l4_no_done_pulse", 32'(pulses), 32'd0);
    op4(1'b0, 2'b10, 1'b0, 32'h20, 32'h0, dn, er, q);
    check("l4_post_rst_done", 32'(dn), 32'h1);
    check("l4_post_rst_data", q, 32'h11223344);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Safety net: a stuck run still produces a failure and the summary.
  initial begin
    #200000;
    n_err++;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
